perf_stats_reporter: RTL and testbench

//  Reader/consumer end of the performance-monitor stats path. Captures each stats

---
 rtl/perf_stats_reporter.sv | 180 ++++++++++++++++++
 tb/tb_perf_stats_reporter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_stats_reporter.sv
// Stats record capture FIFO + framer: A5, seq, util/lat/tput MSB-first [, XOR chk if PERF_RPT_CHKSUM_EN].
// Latency: record written at edge k into idle/empty path -> header byte valid from edge k+1.
// Backpressure: tx bytes held until tx_ready; monitor never stalled, overflow records dropped and counted.
module perf_stats_reporter #(
   parameter int COUNTER_WIDTH = 32,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     stat_valid,
   input  logic [COUNTER_WIDTH-1:0] stat_util,
   input  logic [COUNTER_WIDTH-1:0] stat_lat,
   input  logic [COUNTER_WIDTH-1:0] stat_tput,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_sof,
   output logic                     tx_eof,
   output logic [7:0]               frame_seq,
   output logic [15:0]              drop_count,
   output logic                     busy
);

   localparam int RW  = 3 * COUNTER_WIDTH;
   localparam int NB  = RW / 8;
   localparam int BCW = $clog2(NB);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [BCW-1:0] LAST_IDX = BCW'(NB - 1);
   localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_PAYLOAD, S_CHK} state_t;

   logic [RW-1:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    count_q, count_d;
   logic [15:0]    drop_q;
   state_t         state_q;
   logic [RW-1:0]  frame_q;
   logic [BCW-1:0] byte_cnt_q;
   logic [BCW-1:0] pay_idx;
   logic [RW-1:0]  pay_shift;
   logic [7:0]     pay_byte;
   logic           tx_valid_q, sof_q, eof_q;
   logic [7:0]     tx_data_q, seq_q;
   logic           fifo_full, fifo_empty, push, pop, xfer;

   always_comb begin
      fifo_full  = (count_q == FULL_CNT);
      fifo_empty = (count_q == '0);
      push       = stat_valid & ~fifo_full;
      pop        = (state_q == S_IDLE) & ~fifo_empty;
      xfer       = tx_valid_q & tx_ready;
      count_d    = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
      // byte to present after the current transfer: first payload byte from SEQ, else the next one
      pay_idx    = (state_q == S_PAYLOAD) ? byte_cnt_q + 1'b1 : '0;
      pay_shift  = frame_q << {pay_idx, 3'b000};
      pay_byte   = pay_shift[RW-1 -: 8];
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= {stat_util, stat_lat, stat_tput};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         count_q <= count_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         if (stat_valid && fifo_full && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
      end
   end

`ifdef PERF_RPT_CHKSUM_EN
   logic [7:0] chk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         chk_q <= '0;
      else if (pop)
         chk_q <= '0;
      else if (xfer)
         chk_q <= chk_q ^ tx_data_q;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         frame_q    <= '0;
         byte_cnt_q <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         seq_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  frame_q    <= mem_q[rd_ptr_q];
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= 8'hA5;
                  sof_q      <= 1'b1;
                  eof_q      <= 1'b0;
                  state_q    <= S_HDR;
               end
            end
            S_HDR: begin
               if (xfer) begin
                  tx_data_q <= seq_q;
                  sof_q     <= 1'b0;
                  state_q   <= S_SEQ;
               end
            end
            S_SEQ: begin
               if (xfer) begin
                  tx_data_q  <= pay_byte;
                  byte_cnt_q <= '0;
                  state_q    <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (xfer) begin
                  if (byte_cnt_q == LAST_IDX) begin
`ifdef PERF_RPT_CHKSUM_EN
                     tx_data_q <= chk_q ^ tx_data_q;
                     eof_q     <= 1'b1;
                     state_q   <= S_CHK;
`else
                     tx_valid_q <= 1'b0;
                     eof_q      <= 1'b0;
                     seq_q      <= seq_q + 8'd1;
                     state_q    <= S_IDLE;
`endif
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                     tx_data_q  <= pay_byte;
`ifndef PERF_RPT_CHKSUM_EN
                     eof_q      <= (byte_cnt_q + 1'b1 == LAST_IDX);
`endif
                  end
               end
            end
`ifdef PERF_RPT_CHKSUM_EN
            S_CHK: begin
               if (xfer) begin
                  tx_valid_q <= 1'b0;
                  eof_q      <= 1'b0;
                  seq_q      <= seq_q + 8'd1;
                  state_q    <= S_IDLE;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx_valid   = tx_valid_q;
   assign tx_data    = tx_data_q;
   assign tx_sof     = sof_q;
   assign tx_eof     = eof_q;
   assign frame_seq  = seq_q;
   assign drop_count = drop_q;
   assign busy       = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_perf_stats_reporter.sv
// Self-checking bench for perf_stats_reporter: vector table, overflow/wrap/reset sequences, random traffic vs frame model.
module tb_perf_stats_reporter;

   localparam int CW    = 32;
   localparam int DEPTH = 4;
`ifdef PERF_RPT_CHKSUM_EN
   localparam int FLEN  = 3 * CW / 8 + 3;
`else
   localparam int FLEN  = 3 * CW / 8 + 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stat_valid;
   logic [CW-1:0] stat_util, stat_lat, stat_tput;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_sof, tx_eof;
   logic [7:0]    frame_seq;
   logic [15:0]   drop_count;
   logic          busy;

   perf_stats_reporter #(.COUNTER_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .stat_valid(stat_valid),
      .stat_util(stat_util), .stat_lat(stat_lat), .stat_tput(stat_tput),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .tx_sof(tx_sof), .tx_eof(tx_eof), .frame_seq(frame_seq),
      .drop_count(drop_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       sof;
      logic       eof;
   } byte_t;

   typedef struct {
      logic [CW-1:0] util;
      logic [CW-1:0] lat;
      logic [CW-1:0] tput;
      int            mode;
      logic [7:0]    seq_after;
   } vec_t;

   byte_t      rx_q[$];
   byte_t      exp_q[$];
   int         n_cmp = 0;
   int         n_fail = 0;
   int         eof_cnt = 0;
   int         rdy_mode = 1;
   logic [7:0] exp_seq;
   logic [15:0] exp_drop;

   logic       prev_stall = 1'b0;
   logic [7:0] prev_d;
   logic       prev_sof, prev_eof;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ready patterns: 0 stalled, 1 always, 2 toggling, 3 random
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       tx_ready = 1'b0;
         1:       tx_ready = 1'b1;
         2:       tx_ready = ~tx_ready;
         default: tx_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("stall_hold", {tx_valid, tx_sof, tx_eof, tx_data}, {1'b1, prev_sof, prev_eof, prev_d});
         if (tx_valid && tx_ready) begin
            rx_q.push_back('{d: tx_data, sof: tx_sof, eof: tx_eof});
            if (tx_eof)
               eof_cnt++;
         end
         prev_stall = tx_valid && !tx_ready;
         prev_d     = tx_data;
         prev_sof   = tx_sof;
         prev_eof   = tx_eof;
      end
   end

   // Reference framing: header, seq, each field MSB first, optional XOR of everything before.
   task automatic add_frame(input logic [CW-1:0] u, input logic [CW-1:0] l, input logic [CW-1:0] t);
      logic [7:0]    b[$];
      logic [CW-1:0] val;
      logic [7:0]    x;
      b.push_back(8'hA5);
      b.push_back(exp_seq);
      for (int f = 0; f < 3; f++) begin
         val = (f == 0) ? u : (f == 1) ? l : t;
         for (int k = CW / 8 - 1; k >= 0; k--)
            b.push_back(8'(val >> (8 * k)));
      end
`ifdef PERF_RPT_CHKSUM_EN
      x = 8'h00;
      foreach (b[i]) x = x ^ b[i];
      b.push_back(x);
`else
      x = 8'h00;
`endif
      foreach (b[i])
         exp_q.push_back('{d: b[i], sof: (i == 0), eof: (i == b.size() - 1)});
      exp_seq = exp_seq + 8'd1;
   endtask

   task automatic send(input logic [CW-1:0] u, input logic [CW-1:0] l, input logic [CW-1:0] t);
      @(posedge clk); #1;
      stat_util = u; stat_lat = l; stat_tput = t; stat_valid = 1'b1;
      @(posedge clk); #1;
      stat_valid = 1'b0;
      add_frame(u, l, t);
   endtask

   task automatic wait_eof(input int target, input int budget);
      int c = 0;
      while (eof_cnt < target && c < budget) begin
         @(negedge clk); #1;
         c++;
      end
      check("eof_timeout", 64'(eof_cnt >= target), 64'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic compare_stream(input string name);
      int n;
      check({name, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (rx_q[i] != exp_q[i]) begin
            n_fail++;
            $display("FAIL %s byte %0d: got d=%h sof=%b eof=%b expected d=%h sof=%b eof=%b",
                     name, i, rx_q[i].d, rx_q[i].sof, rx_q[i].eof, exp_q[i].d, exp_q[i].sof, exp_q[i].eof);
            break;
         end
      end
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      vec_t vecs[4];
      int   base;
      int   npush;
      int   c;
      logic [7:0] x;
      vecs[0] = '{32'h00000032, 32'h11223344, 32'hAABBCCDD, 1, 8'd1};
      vecs[1] = '{32'h00000032, 32'h11223344, 32'hAABBCCDD, 2, 8'd2};
      vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 32'h80000001, 3, 8'd3};
      vecs[3] = '{32'h00000000, 32'h00000000, 32'h00000000, 1, 8'd4};

      rst_n = 1'b0; stat_valid = 1'b0;
      stat_util = '0; stat_lat = '0; stat_tput = '0;
      exp_seq = 8'd0; exp_drop = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {tx_valid, tx_sof, tx_eof, tx_data, frame_seq, drop_count, busy}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 4; i++) begin
         rdy_mode = vecs[i].mode;
         base = eof_cnt;
         if (i == 0) begin
            @(posedge clk); #1;
            stat_util = vecs[i].util; stat_lat = vecs[i].lat; stat_tput = vecs[i].tput;
            stat_valid = 1'b1;
            @(posedge clk); #1;
            stat_valid = 1'b0;
            add_frame(vecs[i].util, vecs[i].lat, vecs[i].tput);
            @(negedge clk);
            check("latency_edge_k", 64'(tx_valid), 64'd0);
            @(negedge clk);
            check("latency_edge_k1", {tx_valid, tx_sof, tx_data}, {1'b1, 1'b1, 8'hA5});
         end else begin
            send(vecs[i].util, vecs[i].lat, vecs[i].tput);
         end
         wait_eof(base + 1, 400);
         check("vec_seq_after", 64'(frame_seq), 64'(vecs[i].seq_after));
         check("vec_frame_len", 64'(rx_q.size()), 64'(FLEN));
         check("vec_idle", 64'(busy), 64'd0);
`ifdef PERF_RPT_CHKSUM_EN
         if (rx_q.size() == FLEN) begin
            x = 8'h00;
            for (int k = 0; k < FLEN - 1; k++) x = x ^ rx_q[k].d;
            check("chk_byte_xor", 64'(rx_q[FLEN-1].d), 64'(x));
         end
`endif
         compare_stream("vec");
      end

      // overflow: 6 back-to-back records with the link stalled
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      base = eof_cnt;
      for (int j = 0; j < 6; j++) begin
         @(posedge clk); #1;
         stat_util = 32'h100 + 32'(j); stat_lat = 32'h200 + 32'(j); stat_tput = 32'h300 + 32'(j);
         stat_valid = 1'b1;
         if (j < 5) add_frame(stat_util, stat_lat, stat_tput);
      end
      @(posedge clk); #1;
      stat_valid = 1'b0;
      exp_drop = exp_drop + 16'd1;
      repeat (4) @(posedge clk);
      #1;
      check("ovf_drop", 64'(drop_count), 64'(exp_drop));
      check("ovf_held", {tx_valid, tx_sof, tx_data, busy}, {1'b1, 1'b1, 8'hA5, 1'b1});
      check("ovf_nothing_sent", 64'(rx_q.size()), 64'd0);
      rdy_mode = 1;
      wait_eof(base + 5, 500);
      check("ovf_seq", 64'(frame_seq), 64'(exp_seq));
      compare_stream("ovf");

      // random records and random ready, kept within FIFO capacity
      rdy_mode = 3;
      base = eof_cnt;
      npush = 0;
      for (int n = 0; n < 30; n++) begin
         repeat ($urandom_range(0, 12)) @(posedge clk);
         c = 0;
         while (npush - (eof_cnt - base) >= DEPTH && c < 500) begin
            @(negedge clk); #1;
            c++;
         end
         send($urandom, $urandom, $urandom);
         npush++;
      end
      wait_eof(base + 30, 4000);
      check("rand_seq", 64'(frame_seq), 64'(exp_seq));
      check("rand_drop", 64'(drop_count), 64'(exp_drop));
      compare_stream("rand");

      // asynchronous reset while byte 5 of a frame is on the link
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      send(32'h01020304, 32'h05060708, 32'h090A0B0C);
      c = 0;
      while (rx_q.size() < 6 && c < 50) begin
         @(negedge clk); #1;
         c++;
      end
      check("rst_reached_byte5", 64'(rx_q.size()), 64'd6);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_valid", 64'(tx_valid), 64'd0);
      check("rst_state", {frame_seq, drop_count, busy}, 64'd0);
      rx_q.delete();
      exp_q.delete();
      exp_seq = 8'd0;
      exp_drop = 16'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 256 frames from reset wrap frame_seq; the 257th carries seq 00
      base = eof_cnt;
      for (int f = 0; f < 256; f++) begin
         send($urandom, 32'(f), 32'hC0DE0000 | 32'(f));
         wait_eof(base + f + 1, 100);
      end
      check("seq_wrap", 64'(frame_seq), 64'd0);
      send(32'h00000032, 32'h11223344, 32'hAABBCCDD);
      wait_eof(base + 257, 100);
      if (rx_q.size() == 257 * FLEN)
         check("frame257_seq", {rx_q[256*FLEN].d, rx_q[256*FLEN+1].d}, {8'hA5, 8'h00});
      else
         check("frame257_len", 64'(rx_q.size()), 64'(257 * FLEN));
      check("seq_after_257", 64'(frame_seq), 64'd1);
      compare_stream("wrap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
